reg_file: RTL
=============

# reg_file

Parametrised multi-bit register file with two combinational read ports, one synchronous write port, per-entry valid tracking and a sequenced bulk-clear engine. It is the next-generation storage block of the CPU datapath: it holds operand registers, feeds both ALU operand buses in the same cycle, and accepts one result write per cycle.

## Interface
Parameters:
- DATA_WIDTH, 8, bits per entry.
- ADDR_WIDTH, 4, address bits; depth is fixed at 2**ADDR_WIDTH entries.
- BYPASS, 1, 1 = a read of the address being written this cycle returns wdata (write-first); 0 = it returns the stored value.
- R0_ZERO, 0, 1 = entry 0 is hard-wired to zero and always valid, and writes to it are discarded.

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- rst_n  in  1  asynchronous active-low reset.
- raddr_a  in  ADDR_WIDTH  read address, port A.
- rdata_a  out  DATA_WIDTH  read data, port A (combinational).
- rvalid_a  out  1  entry A written since the last reset or clear.
- raddr_b  in  ADDR_WIDTH  read address, port B.
- rdata_b  out  DATA_WIDTH  read data, port B.
- rvalid_b  out  1  valid flag, port B.
- we  in  1  write enable.
- waddr  in  ADDR_WIDTH  write address.
- wdata  in  DATA_WIDTH  write data.
- clr  in  1  single-cycle request to start a bulk clear.
- busy  out  1  clear sweep in progress.
- wr_drop  out  1  registered one-cycle pulse: a write was discarded during a sweep.

## Operation
- Storage: 2**ADDR_WIDTH x DATA_WIDTH flops plus one valid bit per entry.
- Reads are purely combinational from raddr_x. rdata_x is the stored value and rvalid_x is the stored valid bit, except in the two cases below.
- Bypass (BYPASS=1): when we=1, the write is accepted and waddr==raddr_x, rdata_x = wdata and rvalid_x = 1 in the same cycle.
- R0_ZERO=1: a read of address 0 returns 0 with rvalid=1. Writes to address 0 are silently ignored, do not bypass, and do not raise wr_drop.
- Write: when we=1 in IDLE, entry[waddr] <= wdata and valid[waddr] <= 1 at the edge.
- FSM states are IDLE and SWEEP.
  - IDLE -> SWEEP: clr=1 at a rising edge. The sweep counter is loaded with 0.
  - In SWEEP, each edge clears entry[cnt] to 0 and valid[cnt] to 0, then increments cnt.
  - SWEEP -> IDLE: on the edge that clears entry 2**ADDR_WIDTH-1.
- clr while in SWEEP: ignored. The sweep is not restarted.
- clr and we together in IDLE: clr wins and the write is dropped (wr_drop pulses).
- we=1 in SWEEP: the write is discarded and wr_drop=1 for the following cycle. Bypass is suppressed for discarded writes.
- Reads during SWEEP return the current array contents. Entries already swept read 0/invalid.
- Reset (asynchronous, any time, including mid-sweep):
  - all entries 0, all valid bits 0;
  - FSM to IDLE, cnt 0;
  - busy 0, wr_drop 0.

## Timing
- Read latency is 0 cycles (combinational).
- Write is visible on the read ports from the cycle after the edge, or in the same cycle through bypass.
- Sweep: with clr sampled at edge N, busy=1 after edge N through edge N+2**ADDR_WIDTH. That is exactly 2**ADDR_WIDTH cycles high. Entry k is cleared at edge N+1+k.
- busy is registered and glitch-free. A new clr is accepted at the edge where busy is already 0.
- wr_drop is registered and high for exactly one cycle per dropped write. Back-to-back drops keep it high.
- Reset values of outputs: busy=0, wr_drop=0. rdata_x=0 and rvalid_x=0, except address 0 with R0_ZERO=1, which gives rvalid=1.

## Test plan
- Reset, then write 0xA5 to addr 3 and 0x5A to addr 7, then read A=3, B=7: returns 0xA5/0x5A with both valid; unwritten addr 9 reads 0x00 with valid 0.
- Bypass, BYPASS=1: we=1, waddr=4, wdata=0x3C with raddr_a=4 in the same cycle: rdata_a=0x3C and rvalid_a=1 before the edge. With BYPASS=0 the port returns the old value.
- Clear sweep, depth 16: fill all entries, then pulse clr. busy is high for exactly 16 cycles. Entry 5 reads 0/invalid from the cycle after edge N+6, while entry 6 still holds its value. A second clr mid-sweep does not extend busy.
- Write during sweep: we=1 to addr 15 while busy. wr_drop pulses for 1 cycle, and after the sweep addr 15 reads 0 with valid 0.
- R0_ZERO=1: write 0xFF to addr 0. A read returns 0x00 with valid 1, and wr_drop stays 0.
- Reset mid-sweep: assert rst_n=0 at cycle 3 of a sweep. busy drops immediately and all entries read 0/invalid. A new clr after release runs a full 16-cycle sweep.

Source files
------------

// File: rtl/reg_file.sv
// reg_file: multi-entry register file with two combinational read ports,
// one synchronous write port, per-entry valid bits and a sequenced
// bulk-clear engine that sweeps every entry back to zero/invalid.
module reg_file #(
  parameter int DATA_WIDTH = 8,
  parameter int ADDR_WIDTH = 4,
  parameter int BYPASS     = 1,
  parameter int R0_ZERO    = 0
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [ADDR_WIDTH-1:0] raddr_a,
  output logic [DATA_WIDTH-1:0] rdata_a,
  output logic                  rvalid_a,
  input  logic [ADDR_WIDTH-1:0] raddr_b,
  output logic [DATA_WIDTH-1:0] rdata_b,
  output logic                  rvalid_b,
  input  logic                  we,
  input  logic [ADDR_WIDTH-1:0] waddr,
  input  logic [DATA_WIDTH-1:0] wdata,
  input  logic                  clr,
  output logic                  busy,
  output logic                  wr_drop
);

  localparam int DEPTH = 1 << ADDR_WIDTH;

  typedef enum logic {
    IDLE  = 1'b0,
    SWEEP = 1'b1
  } state_t;

  state_t                  state;
  state_t                  state_nxt;
  logic [ADDR_WIDTH-1:0]   cnt;
  logic [ADDR_WIDTH-1:0]   cnt_nxt;
  logic [DATA_WIDTH-1:0]   mem [DEPTH];
  logic [DEPTH-1:0]        vld;

  // Writes to a hard-wired zero entry vanish silently: no store, no bypass, no drop flag.
  logic w_zero;
  // A write lands only in IDLE when no clear is being requested on the same edge.
  logic wr_acc;
  // A non-zero-entry write loses to an active sweep or to a simultaneous clear.
  logic drop_nxt;

  assign w_zero   = (R0_ZERO != 0) && (waddr == '0);
  assign wr_acc   = we && (state == IDLE) && !clr && !w_zero;
  assign drop_nxt = we && !w_zero && ((state == SWEEP) || clr);
  assign busy     = (state == SWEEP);

  // Next-state logic: clr in IDLE launches a sweep from entry 0; the sweep
  // ends on the edge that clears the last entry. clr during a sweep is ignored.
  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    case (state)
      IDLE: begin
        if (clr) begin
          state_nxt = SWEEP;
          cnt_nxt   = '0;
        end
      end
      SWEEP: begin
        cnt_nxt = cnt + 1'b1;
        if (&cnt) begin
          state_nxt = IDLE;
        end
      end
      default: begin
        state_nxt = IDLE;
        cnt_nxt   = '0;
      end
    endcase
  end

  // Control registers: FSM state, sweep pointer and the registered drop pulse.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= IDLE;
      cnt     <= '0;
      wr_drop <= 1'b0;
    end else begin
      state   <= state_nxt;
      cnt     <= cnt_nxt;
      wr_drop <= drop_nxt;
    end
  end

  // Storage: sweep clears one entry per edge, otherwise accepted writes land.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem[i] <= '0;
      end
      vld <= '0;
    end else if (state == SWEEP) begin
      mem[cnt] <= '0;
      vld[cnt] <= 1'b0;
    end else if (wr_acc) begin
      mem[waddr] <= wdata;
      vld[waddr] <= 1'b1;
    end
  end

  // Read port A: zero entry overrides, then write-first bypass, then storage.
  always_comb begin
    rdata_a  = mem[raddr_a];
    rvalid_a = vld[raddr_a];
    if ((R0_ZERO != 0) && (raddr_a == '0)) begin
      rdata_a  = '0;
      rvalid_a = 1'b1;
    end else if ((BYPASS != 0) && wr_acc && (waddr == raddr_a)) begin
      rdata_a  = wdata;
      rvalid_a = 1'b1;
    end
  end

  // Read port B: same selection rules as port A.
  always_comb begin
    rdata_b  = mem[raddr_b];
    rvalid_b = vld[raddr_b];
    if ((R0_ZERO != 0) && (raddr_b == '0)) begin
      rdata_b  = '0;
      rvalid_b = 1'b1;
    end else if ((BYPASS != 0) && wr_acc && (waddr == raddr_b)) begin
      rdata_b  = wdata;
      rvalid_b = 1'b1;
    end
  end

endmodule
